bandai_eeprom_port: RTL

- Cartridge-side serial EEPROM port that sits beside the mapper's bank-register decoder.
- The bank/lock stage decodes the cartridge I/O window. It forwards register writes and reads for ports C4h–C8h to this block, together with an unlock qualifier.
- This block converts those register accesses into Microwire (93Cx6, x16 organisation) transactions. It then exposes read data and status back to the console.

---
 rtl/bandai_eeprom_port_if.sv | 23 ++
 rtl/bandai_eeprom_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bandai_eeprom_port_if.sv
// Console register bus plus Microwire pins for the cartridge EEPROM port.
interface bandai_eeprom_port_if;
  logic       en;
  logic [7:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ee_cs;
  logic       ee_sk;
  logic       ee_di;
  logic       ee_do;
  logic       busy;

  modport master (
    output en, addr, we, wdata, ee_do,
    input  rdata, ee_cs, ee_sk, ee_di, busy
  );

  modport slave (
    input  en, addr, we, wdata, ee_do,
    output rdata, ee_cs, ee_sk, ee_di, busy
  );
endinterface

// File: rtl/bandai_eeprom_port.sv
// Bandai mapper EEPROM port: turns C4h-C8h register accesses into 93Cx6 (x16)
// Microwire transactions and reports read data and status back to the console.
module bandai_eeprom_port #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                clk,
  input  logic                rst,
  bandai_eeprom_port_if.slave bus
);

  localparam int unsigned CMD_BITS = ADDR_BITS + 3;
  localparam int unsigned DIV_W    = $clog2(2 * CLK_DIV);
  localparam int unsigned BIT_W    = $clog2(CMD_BITS + 16);
  localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_CMD         = 3'd1;
  localparam logic [2:0] S_DIN         = 3'd2;
  localparam logic [2:0] S_DOUT        = 3'd3;
  localparam logic [2:0] S_DESEL       = 3'd4;
  localparam logic [2:0] S_POLL        = 3'd5;
  localparam logic [2:0] S_DESEL_FINAL = 3'd6;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CMD   = 2'd2;

  logic [2:0]          state,    state_d;
  logic [1:0]          op,       op_d;
  logic [15:0]         data,     data_d;
  logic [15:0]         cmd,      cmd_d;
  logic [CMD_BITS-1:0] sr,       sr_d;
  logic [DIV_W-1:0]    div,      div_d;
  logic                ph,       ph_d;
  logic [BIT_W-1:0]    bit_cnt,  bit_cnt_d;
  logic [TMO_W-1:0]    tmo,      tmo_d;
  logic                done,     done_d;
  logic                tmo_flag, tmo_flag_d;
  logic                cs,       cs_d;
  logic                sk,       sk_d;
  logic                di,       di_d;
  logic                busy,     busy_d;
  logic                fin;
  logic                half_end;
  logic                last_bit;

  assign half_end = (div == DIV_W'(CLK_DIV - 1));
  assign last_bit = (state == S_CMD) ? (bit_cnt == BIT_W'(CMD_BITS - 1))
                                     : (bit_cnt == BIT_W'(15));

  // State and datapath registers; reset drops CS immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op       <= OP_READ;
      data     <= '0;
      cmd      <= '0;
      sr       <= '0;
      div      <= '0;
      ph       <= 1'b0;
      bit_cnt  <= '0;
      tmo      <= '0;
      done     <= 1'b0;
      tmo_flag <= 1'b0;
      cs       <= 1'b0;
      sk       <= 1'b0;
      di       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      op       <= op_d;
      data     <= data_d;
      cmd      <= cmd_d;
      sr       <= sr_d;
      div      <= div_d;
      ph       <= ph_d;
      bit_cnt  <= bit_cnt_d;
      tmo      <= tmo_d;
      done     <= done_d;
      tmo_flag <= tmo_flag_d;
      cs       <= cs_d;
      sk       <= sk_d;
      di       <= di_d;
      busy     <= busy_d;
    end
  end

  // Next state: bus writes in IDLE, SK phase generation, shifting, polling.
  always_comb begin
    state_d    = state;
    op_d       = op;
    data_d     = data;
    cmd_d      = cmd;
    sr_d       = sr;
    div_d      = div;
    ph_d       = ph;
    bit_cnt_d  = bit_cnt;
    tmo_d      = tmo;
    done_d     = done;
    tmo_flag_d = tmo_flag;
    cs_d       = cs;
    sk_d       = sk;
    di_d       = di;
    busy_d     = busy;
    fin        = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.en && bus.we) begin
          case (bus.addr)
            8'hC4: data_d[7:0]  = bus.wdata;
            8'hC5: data_d[15:8] = bus.wdata;
            8'hC6: cmd_d[7:0]   = bus.wdata;
            8'hC7: cmd_d[15:8]  = bus.wdata;
            8'hC8: if (bus.wdata[6:4] != 3'b000) begin
              if (bus.wdata[4])      op_d = OP_READ;
              else if (bus.wdata[5]) op_d = OP_WRITE;
              else                   op_d = OP_CMD;
              state_d    = S_CMD;
              done_d     = 1'b0;
              tmo_flag_d = 1'b0;
              busy_d     = 1'b1;
              cs_d       = 1'b1;
              sk_d       = 1'b0;
              di_d       = 1'b1;
              sr_d       = {1'b1, cmd[ADDR_BITS+1:0]};
              div_d      = '0;
              ph_d       = 1'b0;
              bit_cnt_d  = '0;
            end
            default: ;
          endcase
        end
      end

      S_CMD, S_DIN, S_DOUT: begin
        if (!half_end) begin
          div_d = div + 1'b1;
        end else begin
          div_d = '0;
          ph_d  = ~ph;
          sk_d  = ~ph;
          // End of the high phase: one bit period completed.
          if (ph) begin
            bit_cnt_d = last_bit ? '0 : bit_cnt + 1'b1;
            if (state == S_CMD) begin
              sr_d = {sr[CMD_BITS-2:0], sr[CMD_BITS-1]};
              di_d = sr[CMD_BITS-2];
              if (last_bit) begin
                if (op == OP_READ) begin
                  state_d = S_DIN;
                  di_d    = 1'b0;
                end else if (op == OP_WRITE) begin
                  state_d = S_DOUT;
                  di_d    = data[15];
                end else begin
                  state_d = S_DESEL;
                  cs_d    = 1'b0;
                  di_d    = 1'b0;
                end
              end
            end else if (state == S_DIN) begin
              data_d = {data[14:0], bus.ee_do};
              if (last_bit) begin
                state_d = S_DESEL_FINAL;
                cs_d    = 1'b0;
              end
            end else begin
              // Rotate so the data register is intact after 16 bits.
              data_d = {data[14:0], data[15]};
              di_d   = data[14];
              if (last_bit) begin
                state_d = S_DESEL;
                cs_d    = 1'b0;
                di_d    = 1'b0;
              end
            end
          end
        end
      end

      S_DESEL: begin
        if (div == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d = '0;
          if (op == OP_WRITE || cmd[ADDR_BITS+1:ADDR_BITS] != 2'b00) begin
            state_d = S_POLL;
            cs_d    = 1'b1;
            tmo_d   = '0;
          end else begin
            fin = 1'b1;
          end
        end else begin
          div_d = div + 1'b1;
        end
      end

      S_POLL: begin
        if (bus.ee_do) begin
          fin = 1'b1;
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          tmo_flag_d = 1'b1;
          fin        = 1'b1;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end

      S_DESEL_FINAL: fin = 1'b1;

      default: state_d = S_IDLE;
    endcase

    // Completion collapses straight back to IDLE.
    if (fin) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cs_d    = 1'b0;
      sk_d    = 1'b0;
      di_d    = 1'b0;
    end
  end

  // Combinational register read-back, masked while locked.
  always_comb begin
    bus.rdata = 8'hFF;
    if (bus.en) begin
      case (bus.addr)
        8'hC4:   bus.rdata = data[7:0];
        8'hC5:   bus.rdata = data[15:8];
        8'hC6:   bus.rdata = cmd[7:0];
        8'hC7:   bus.rdata = cmd[15:8];
        8'hC8:   bus.rdata = {tmo_flag, 5'b00000, ~busy, done};
        default: bus.rdata = 8'hFF;
      endcase
    end
  end

  assign bus.ee_cs = cs;
  assign bus.ee_sk = sk;
  assign bus.ee_di = di;
  assign bus.busy  = busy;

endmodule
